// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
// Used by the writeback stage, the register file and the writeback arbiter.
//   REG_IDX_W : register index width
//   DATA_W    : register data width
//   ZERO_REG  : hard-wired zero register; writes to it are dropped
//   wb_req_t  : one writeback request {rd, data}
package regfile_writeback_arbiter_pkg;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;
endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of all writeback-arbiter bus signals.
//   master : environment side (writeback stage, long-latency units, hazard unit)
//   slave  : arbiter side
// Handshakes: pipe_valid has no backpressure. A long-latency result transfers
// on a cycle where lu_valid and lu_ready are both high; lu_valid/lu_rd/lu_data
// must stay stable while lu_valid is high and lu_ready is low.
interface regfile_writeback_arbiter_if;
    import regfile_writeback_arbiter_pkg::*;

    logic                 pipe_valid;
    logic [REG_IDX_W-1:0] pipe_rd;
    logic [DATA_W-1:0]    pipe_data;
    logic                 lu_valid;
    logic                 lu_ready;
    logic [REG_IDX_W-1:0] lu_rd;
    logic [DATA_W-1:0]    lu_data;
    logic                 RegWrite;
    logic [REG_IDX_W-1:0] Write_register;
    logic [DATA_W-1:0]    Write_data;
    logic [REG_IDX_W-1:0] rs_q;
    logic [REG_IDX_W-1:0] rt_q;
    logic                 rs_pending;
    logic                 rt_pending;
    logic                 stall_req;
    logic                 protocol_err;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  RegWrite, Write_register, Write_data,
        output rs_q, rt_q,
        input  rs_pending, rt_pending,
        input  stall_req, protocol_err
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output RegWrite, Write_register, Write_data,
        input  rs_q, rt_q,
        output rs_pending, rt_pending,
        output stall_req, protocol_err
    );
endinterface

// File: rtl/regfile_writeback_arbiter_fifo.sv
// wb_result_fifo: DEPTH-entry circular buffer of long-latency results.
//   clk, reset     : clock, asynchronous active-low reset (empties the buffer)
//   push, push_req : enqueue push_req at the tail
//   pop            : dequeue the head
//   head           : oldest entry
//   count          : number of entries held (registered)
//   entry_rd       : rd of each storage slot
//   entry_valid    : slot currently holds a live entry
// push while full and pop while empty are not allowed by the caller.
module wb_result_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  wb_req_t                             push_req,
    input  logic                                pop,
    output wb_req_t                             head,
    output logic [$clog2(DEPTH+1)-1:0]          count,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]     entry_rd,
    output logic [DEPTH-1:0]                    entry_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: liveness is decided by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt_q;

    // A slot is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        entry_rd    = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - rd_ptr;
            entry_rd[i]    = mem[i].rd;
            entry_valid[i] = (CNT_W'(offset) < cnt_q);
        end
    end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: drives the register-file write port from
// single-cycle writeback results and buffered long-latency results.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : pipe/lu request inputs, registered write port
//           (RegWrite/Write_register/Write_data), hazard queries and
//           pending flags, stall_req and sticky protocol_err
// Priority: pipe result, then FIFO head, then bypass of a fresh lu result
// when the FIFO is empty. Writes to register 0 are accepted and dropped.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    regfile_writeback_arbiter_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SW    = $clog2(STARVE_LIMIT+1);

    wb_req_t                        head;
    logic [CNT_W-1:0]               count;
    logic [DEPTH-1:0][REG_IDX_W-1:0] entry_rd;
    logic [DEPTH-1:0]               entry_valid;

    logic                 reg_write_q;
    logic [REG_IDX_W-1:0] write_reg_q;
    logic [DATA_W-1:0]    write_data_q;
    logic [SW-1:0]        starve_q;
    logic                 stall_q;
    logic                 perr_q;

    logic fifo_empty, pipe_take, lu_hs, lu_live;
    logic grant_pipe, grant_fifo, grant_bypass, push;
    wb_req_t win_req;

    assign fifo_empty = (count == '0);
    // Ready depends on the registered count only, so a full FIFO refuses
    // even in a cycle where it pops.
    assign bus.lu_ready = (count < CNT_W'(DEPTH));

    assign pipe_take    = bus.pipe_valid && (bus.pipe_rd != ZERO_REG);
    assign lu_hs        = bus.lu_valid && bus.lu_ready;
    assign lu_live      = lu_hs && (bus.lu_rd != ZERO_REG);
    assign grant_pipe   = pipe_take;
    assign grant_fifo   = !pipe_take && !fifo_empty;
    assign grant_bypass = !pipe_take && fifo_empty && lu_live;
    assign push         = lu_live && !grant_bypass;

    always_comb begin
        win_req = '0;
        if (grant_pipe)        win_req = '{rd: bus.pipe_rd, data: bus.pipe_data};
        else if (grant_fifo)   win_req = head;
        else if (grant_bypass) win_req = '{rd: bus.lu_rd, data: bus.lu_data};
    end

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_req    ('{rd: bus.lu_rd, data: bus.lu_data}),
        .pop         (grant_fifo),
        .head        (head),
        .count       (count),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q <= grant_pipe || grant_fifo || grant_bypass;
            if (grant_pipe || grant_fifo || grant_bypass) begin
                write_reg_q  <= win_req.rd;
                write_data_q <= win_req.data;
            end
        end
    end

    // Starvation: counts pipe wins over a non-empty FIFO. stall_req follows
    // the saturated counter one edge later and drops on the popping edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (grant_fifo || fifo_empty)
                starve_q <= '0;
            else if (grant_pipe && starve_q != SW'(STARVE_LIMIT))
                starve_q <= starve_q + 1'b1;

            if (grant_fifo)
                stall_q <= 1'b0;
            else if (starve_q == SW'(STARVE_LIMIT))
                stall_q <= 1'b1;

            if (bus.pipe_valid && stall_q)
                perr_q <= 1'b1;
        end
    end

    always_comb begin
        bus.rs_pending = 1'b0;
        bus.rt_pending = 1'b0;
        if (reg_write_q && write_reg_q == bus.rs_q) bus.rs_pending = 1'b1;
        if (reg_write_q && write_reg_q == bus.rt_q) bus.rt_pending = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_rd[i] == bus.rs_q) bus.rs_pending = 1'b1;
            if (entry_valid[i] && entry_rd[i] == bus.rt_q) bus.rt_pending = 1'b1;
        end
        if (bus.rs_q == ZERO_REG) bus.rs_pending = 1'b0;
        if (bus.rt_q == ZERO_REG) bus.rt_pending = 1'b0;
    end

    assign bus.RegWrite       = reg_write_q;
    assign bus.Write_register = write_reg_q;
    assign bus.Write_data     = write_data_q;
    assign bus.stall_req      = stall_q;
    assign bus.protocol_err   = perr_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed scenarios followed by a randomized run, each cycle checked against
// a queue-based reference model of the writeback arbiter.
module tb_regfile_writeback_arbiter;
    import regfile_writeback_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    regfile_writeback_arbiter_if bus ();

    regfile_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    wb_req_t     fifo_q[$];
    bit          m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    int          m_starve;
    bit          m_stall;
    bit          m_perr;

    task automatic model_reset();
        fifo_q.delete();
        m_we = 0; m_wr = '0; m_wd = '0;
        m_starve = 0; m_stall = 0; m_perr = 0;
    endtask

    function automatic bit m_pend(logic [4:0] x);
        if (x == 5'd0) return 1'b0;
        if (m_we && m_wr == x) return 1'b1;
        foreach (fifo_q[i]) if (fifo_q[i].rd == x) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one clock of the arbitration rules to the model state.
    task automatic model_step();
        bit pipe_take, lu_live, bypass, popped;
        int size_before;
        size_before = fifo_q.size();
        pipe_take = bus.pipe_valid && bus.pipe_rd != 5'd0;
        lu_live   = bus.lu_valid && (size_before < DEPTH) && bus.lu_rd != 5'd0;
        bypass = 0;
        popped = 0;
        if (pipe_take) begin
            m_we = 1; m_wr = bus.pipe_rd; m_wd = bus.pipe_data;
        end else if (size_before > 0) begin
            wb_req_t h;
            h = fifo_q.pop_front();
            m_we = 1; m_wr = h.rd; m_wd = h.data;
            popped = 1;
        end else if (lu_live) begin
            m_we = 1; m_wr = bus.lu_rd; m_wd = bus.lu_data;
            bypass = 1;
        end else begin
            m_we = 0;
        end
        if (lu_live && !bypass) fifo_q.push_back('{rd: bus.lu_rd, data: bus.lu_data});
        if (bus.pipe_valid && m_stall) m_perr = 1;
        if (popped) m_stall = 0;
        else if (m_starve == LIMIT) m_stall = 1;
        if (popped || size_before == 0) m_starve = 0;
        else if (pipe_take && m_starve < LIMIT) m_starve++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs were driven at the preceding negedge.
    task automatic cycle();
        #1;
        chk("lu_ready", 32'(bus.lu_ready), 32'(fifo_q.size() < DEPTH));
        chk("rs_pending", 32'(bus.rs_pending), 32'(m_pend(bus.rs_q)));
        chk("rt_pending", 32'(bus.rt_pending), 32'(m_pend(bus.rt_q)));
        model_step();
        @(posedge clk);
        #1;
        chk("RegWrite", 32'(bus.RegWrite), 32'(m_we));
        chk("Write_register", 32'(bus.Write_register), 32'(m_wr));
        chk("Write_data", bus.Write_data, m_wd);
        chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
        chk("protocol_err", 32'(bus.protocol_err), 32'(m_perr));
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid = v; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_rd = rd; bus.lu_data = d;
    endtask

    task automatic idle();
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_lu(1'b0, 5'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle();
        bus.rs_q = '0;
        bus.rt_q = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_Write_register", 32'(bus.Write_register), 32'd0);
        chk("rst_Write_data", bus.Write_data, 32'd0);
        chk("rst_stall_req", 32'(bus.stall_req), 32'd0);
        chk("rst_protocol_err", 32'(bus.protocol_err), 32'd0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        reset = 1'b1;

        // 1: single pipe write, then idle
        drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("t1_we", 32'(bus.RegWrite), 32'd1);
        chk("t1_wr", 32'(bus.Write_register), 32'd5);
        chk("t1_wd", bus.Write_data, 32'hDEADBEEF);
        idle();
        cycle();
        chk("t1_idle_we", 32'(bus.RegWrite), 32'd0);

        // 2: lu bypass, pending only while in the output register
        drive_lu(1'b1, 5'd7, 32'h1234);
        bus.rs_q = 5'd7;
        #1 chk("t2_pend_before", 32'(bus.rs_pending), 32'd0);
        cycle();
        chk("t2_wr", 32'(bus.Write_register), 32'd7);
        idle();
        #1 chk("t2_pend_out", 32'(bus.rs_pending), 32'd1);
        cycle();
        #1 chk("t2_pend_after", 32'(bus.rs_pending), 32'd0);

        // 3: same-cycle pipe and lu
        drive_pipe(1'b1, 5'd3, 32'h33);
        drive_lu(1'b1, 5'd4, 32'h44);
        bus.rt_q = 5'd4;
        cycle();
        chk("t3_wr_first", 32'(bus.Write_register), 32'd3);
        idle();
        #1 chk("t3_pend_fifo", 32'(bus.rt_pending), 32'd1);
        cycle();
        chk("t3_wr_second", 32'(bus.Write_register), 32'd4);
        #1 chk("t3_pend_out", 32'(bus.rt_pending), 32'd1);
        cycle();
        #1 chk("t3_pend_clear", 32'(bus.rt_pending), 32'd0);

        // 4: fill FIFO, third lu waits for a pop, arrival order kept
        drive_pipe(1'b1, 5'd20, 32'h20);
        drive_lu(1'b1, 5'd8, 32'h88);
        cycle();
        drive_pipe(1'b1, 5'd21, 32'h21);
        drive_lu(1'b1, 5'd9, 32'h99);
        cycle();
        drive_pipe(1'b1, 5'd22, 32'h22);
        drive_lu(1'b1, 5'd11, 32'hBB);
        #1 chk("t4_full_ready", 32'(bus.lu_ready), 32'd0);
        cycle();
        drive_pipe(1'b0, 5'd0, 32'd0);
        cycle();
        chk("t4_wr_8", 32'(bus.Write_register), 32'd8);
        cycle();
        chk("t4_wr_9", 32'(bus.Write_register), 32'd9);
        idle();
        cycle();
        chk("t4_wr_11", 32'(bus.Write_register), 32'd11);
        chk("t4_wd_11", bus.Write_data, 32'hBB);

        // 5: starvation, stall, protocol error
        drive_pipe(1'b1, 5'd23, 32'h23);
        drive_lu(1'b1, 5'd10, 32'hA0);
        cycle();
        drive_lu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_stall_yet", 32'(bus.stall_req), 32'd0);
            drive_pipe(1'b1, 5'(24 + i), 32'(i));
            cycle();
        end
        drive_pipe(1'b1, 5'd28, 32'h28);
        cycle();
        chk("t5_stall_set", 32'(bus.stall_req), 32'd1);
        chk("t5_perr_clear", 32'(bus.protocol_err), 32'd0);
        drive_pipe(1'b1, 5'd29, 32'h29);
        cycle();
        chk("t5_pipe_wins", 32'(bus.Write_register), 32'd29);
        chk("t5_perr_set", 32'(bus.protocol_err), 32'd1);
        idle();
        cycle();
        chk("t5_wr_10", 32'(bus.Write_register), 32'd10);
        chk("t5_stall_clear", 32'(bus.stall_req), 32'd0);
        cycle();
        chk("t5_perr_sticky", 32'(bus.protocol_err), 32'd1);

        // 6: rd==0 filtered; reset with FIFO non-empty
        drive_pipe(1'b1, 5'd0, 32'hFFFF);
        drive_lu(1'b1, 5'd0, 32'hEEEE);
        bus.rs_q = 5'd0;
        #1 chk("t6_ready", 32'(bus.lu_ready), 32'd1);
        cycle();
        chk("t6_no_write", 32'(bus.RegWrite), 32'd0);
        chk("t6_rs0", 32'(bus.rs_pending), 32'd0);
        drive_pipe(1'b1, 5'd12, 32'hC0C0);
        drive_lu(1'b1, 5'd13, 32'hD0D0);
        bus.rt_q = 5'd13;
        cycle();
        idle();
        #1 chk("t6_pend_pre", 32'(bus.rt_pending), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_we", 32'(bus.RegWrite), 32'd0);
        chk("t6_rst_wr", 32'(bus.Write_register), 32'd0);
        chk("t6_rst_wd", bus.Write_data, 32'd0);
        chk("t6_rst_perr", 32'(bus.protocol_err), 32'd0);
        chk("t6_rst_pend", 32'(bus.rt_pending), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk("t6_empty_ready", 32'(bus.lu_ready), 32'd1);

        // randomized run; pipe mostly respects stall_req
        for (int n = 0; n < 600; n++) begin
            logic pv;
            pv = (bus.stall_req && $urandom_range(0, 19) != 0) ? 1'b0
                 : ($urandom_range(0, 99) < 65);
            drive_pipe(pv, 5'($urandom_range(0, 15)), $urandom);
            // hold a refused lu request stable
            if (!(bus.lu_valid && !bus.lu_ready))
                drive_lu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
            bus.rs_q = 5'($urandom_range(0, 15));
            bus.rt_q = 5'($urandom_range(0, 15));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Producer side of the register-file write port: merges single-cycle writeback results with results from long-latency units (mul/div, load-miss).
- Drives the register file's write interface (RegWrite, Write_register, Write_data) from registered outputs.
- Buffers long-latency results in a small FIFO.
- Reports pending destination registers to the hazard unit.
- Requests a pipeline stall when buffered results are starved.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles the pipe may win over a non-empty FIFO before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_valid  in  1  writeback-stage result valid; always accepted, no backpressure.
- pipe_rd  in  5  writeback destination register.
- pipe_data  in  32  writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  long-latency result accepted this cycle when high together with lu_valid.
- lu_rd  in  5  long-latency destination register.
- lu_data  in  32  long-latency data.
- RegWrite  out  1  register-file write enable (registered).
- Write_register  out  5  register-file write index (registered).
- Write_data  out  32  register-file write data (registered).
- rs_q  in  5  hazard query index A.
- rt_q  in  5  hazard query index B.
- rs_pending  out  1  rs_q has an outstanding write in FIFO or output register (combinational).
- rt_pending  out  1  same for rt_q.
- stall_req  out  1  pipeline must hold pipe_valid low (registered).
- protocol_err  out  1  sticky: pipe_valid seen while stall_req high.

Behaviour:
- Reset (reset==0, async): RegWrite=0, Write_register=0, Write_data=0, FIFO empty, starvation counter=0, stall_req=0, protocol_err=0.
- Entry filter: any request with rd==0 is accepted but discarded.
  - pipe side: no issue.
  - lu side: handshake completes, no enqueue.
  - Never counted, never pending.
- lu_ready = FIFO count < DEPTH; combinational from registered count only. No pop-to-push pass-through when full.
- Grant each cycle, one write issued:
  - pipe_valid (rd!=0) -> pipe result to output registers at next edge; latency 1.
  - Else FIFO non-empty -> head popped to output registers; latency 1 from grant.
  - Else lu handshake with rd!=0 and FIFO empty -> bypass directly to output registers; latency 1.
  - Else RegWrite=0 next cycle; Write_register/Write_data hold last values.
- lu handshake not taken by bypass -> pushed at tail. Simultaneous push and pop legal at any count < DEPTH.
- Ordering: FIFO entries issue strictly in arrival order. No squashing of same-rd writes; issue order equals grant order.
- Starvation counter:
  - Increments when FIFO non-empty and pipe granted.
  - Clears on any FIFO pop or when FIFO empty.
  - Saturates at STARVE_LIMIT.
  - stall_req is set next edge when counter reaches STARVE_LIMIT.
  - stall_req clears on the edge after the first FIFO pop.
- While stall_req=1: pipe_valid=1 is a protocol violation. Pipe still wins; protocol_err sets and stays set until reset.
- Pending logic:
  - x_pending = (x!=0) AND (match on any valid FIFO entry's rd, OR RegWrite && Write_register==x).
  - Bypass-in-flight lu results are covered via the output register on the following cycle.
- Reset mid-operation: FIFO contents dropped, no partial write; RegWrite low immediately (async).

Decomposition:
- Shared package: REG_IDX_W=5, DATA_W=32, ZERO_REG=5'd0, and a wb_req struct {rd, data}, also used by the writeback stage and the register file.
- One natural sub-module: wb_result_fifo (DEPTH-entry circular buffer with count).
  - Exposes entries' rd and valid bits for the pending comparison.
  - Arbitration, starvation and output registers stay in the top.

Test Plan:
1. Reset release, pipe_valid with rd=5, data=32'hDEADBEEF -> next cycle RegWrite=1, Write_register=5, Write_data=32'hDEADBEEF; following idle cycle RegWrite=0.
2. lu_valid rd=7, data=32'h1234 with FIFO empty, pipe idle -> bypass: RegWrite=1, Write_register=7 next cycle; rs_q=7 reports rs_pending=1 that cycle only.
3. Same-cycle pipe rd=3 and lu rd=4 -> cycle+1 writes reg 3, cycle+2 writes reg 4. rt_q=4 pending=1 during cycle+1 (FIFO) and cycle+2 (output reg).
4. Fill FIFO with rd=8,9 while pipe busy -> lu_ready=0 at count 2. Third lu_valid stalls until a pop; issue order 8, 9, then third.
5. Pipe continuous, FIFO holding rd=10 -> stall_req=1 after 4 pipe grants. Pipe drops valid -> reg 10 written, stall_req clears next edge. Pipe_valid while stall_req -> protocol_err=1 sticky.
6. Writes with rd=0 on both sources -> no RegWrite, lu_ready handshake completes, rs_q=0 never pending. Assert reset with FIFO non-empty -> outputs zero immediately, FIFO empty after release.
